// File: rtl/poly_eval_engine.sv
// Horner-method polynomial evaluator with one multiply-accumulate per cycle.
// Coefficients are writable in IDLE; results are clamped or wrapped to DATA_WIDTH.
module poly_eval_engine #(
    parameter int                                 DATA_WIDTH = 16,
    parameter int                                 DEGREE     = 2,
    parameter logic [(DEGREE+1)*DATA_WIDTH-1:0]   COEF_INIT  = {16'sd2, 16'sd4, 16'sd6},
    parameter bit                                 SATURATE   = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         x,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_WIDTH-1:0]         y,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overflow,
    input  logic                          coef_we,
    input  logic [$clog2(DEGREE+1)-1:0]   coef_addr,
    input  logic [DATA_WIDTH-1:0]         coef_wdata,
    output logic [1:0]                    state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CW = $clog2(DEGREE+1);
    localparam int PW = 2*DATA_WIDTH;
    localparam int SW = 2*DATA_WIDTH + 1;

    localparam logic signed [SW-1:0] SUM_MAX = {{(DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SUM_MIN = {{(DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t                        state_r;
    logic signed [DATA_WIDTH-1:0]  coef [DEGREE+1];
    logic signed [DATA_WIDTH-1:0]  x_r;
    logic signed [DATA_WIDTH-1:0]  acc;
    logic [CW-1:0]                 idx;
    logic [DATA_WIDTH-1:0]         y_r;
    logic                          ovf_r;

    logic signed [PW-1:0]          prod;
    logic signed [SW-1:0]          sum;
    logic signed [DATA_WIDTH-1:0]  coef_sel;
    logic                          sum_hi;
    logic                          sum_lo;
    logic [DATA_WIDTH-1:0]         acc_next;

    // Full-width signed product plus sign-extended coefficient, then clamp or wrap.
    always_comb begin
        coef_sel = coef[idx];
        prod     = $signed({{DATA_WIDTH{acc[DATA_WIDTH-1]}}, acc})
                 * $signed({{DATA_WIDTH{x_r[DATA_WIDTH-1]}}, x_r});
        sum      = $signed({prod[PW-1], prod})
                 + $signed({{(DATA_WIDTH+1){coef_sel[DATA_WIDTH-1]}}, coef_sel});
        sum_hi   = (sum > SUM_MAX);
        sum_lo   = (sum < SUM_MIN);
        acc_next = sum[DATA_WIDTH-1:0];
        if (SATURATE && sum_hi) begin
            acc_next = OUT_MAX;
        end else if (SATURATE && sum_lo) begin
            acc_next = OUT_MIN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            x_r     <= '0;
            acc     <= '0;
            idx     <= '0;
            y_r     <= '0;
            ovf_r   <= 1'b0;
            for (int unsigned i = 0; i <= DEGREE; i++) begin
                coef[i] <= COEF_INIT[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end else begin
            case (state_r)
                IDLE: begin
                    // A write on the accepting edge is visible to the new transaction.
                    if (coef_we && (int'(coef_addr) <= DEGREE)) begin
                        coef[coef_addr] <= coef_wdata;
                    end
                    if (in_valid) begin
                        x_r     <= x;
                        ovf_r   <= 1'b0;
                        state_r <= LOAD;
                    end
                end
                LOAD: begin
                    acc     <= coef[DEGREE];
                    idx     <= CW'(DEGREE-1);
                    state_r <= CALC;
                end
                CALC: begin
                    acc   <= acc_next;
                    ovf_r <= ovf_r | sum_hi | sum_lo;
                    if (idx == '0) begin
                        y_r     <= acc_next;
                        state_r <= DONE;
                    end else begin
                        idx <= idx - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign y         = y_r;
    assign overflow  = ovf_r;
    assign state     = state_r;

endmodule

// File: tb/tb_poly_eval_engine.sv
// Directed scoreboard bench for poly_eval_engine: saturating and wrapping
// instances share stimulus and are checked against a Horner reference model.
module tb_poly_eval_engine;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   x;
    logic           in_valid, out_ready, coef_we;
    logic [1:0]     coef_addr;
    logic [W-1:0]   coef_wdata;

    logic           in_ready_s, out_valid_s, ovf_s;
    logic [W-1:0]   y_s;
    logic [1:0]     state_s;
    logic           in_ready_w, out_valid_w, ovf_w;
    logic [W-1:0]   y_w;
    logic [1:0]     state_w;

    int checks = 0;
    int errors = 0;
    int mc [3];
    bit busy_wr;
    bit keep_valid;
    int last_ys, last_yw;

    typedef struct {
        int ys;
        bit os;
        int yw;
        bit ow;
    } exp_t;
    exp_t sb [$];

    always #5 clk = ~clk;

    poly_eval_engine #(.DATA_WIDTH(W), .DEGREE(2), .COEF_INIT({16'sd2, 16'sd4, 16'sd6}), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .in_ready(in_ready_s),
        .y(y_s), .out_valid(out_valid_s), .out_ready(out_ready), .overflow(ovf_s),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .state(state_s)
    );

    poly_eval_engine #(.DATA_WIDTH(W), .DEGREE(2), .COEF_INIT({16'sd2, 16'sd4, 16'sd6}), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .in_ready(in_ready_w),
        .y(y_w), .out_valid(out_valid_w), .out_ready(out_ready), .overflow(ovf_w),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .state(state_w)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input int xv, input bit sat, output int yv, output bit ov);
        longint acc, s, wv;
        acc = mc[2];
        ov  = 1'b0;
        for (int i = 1; i >= 0; i--) begin
            s = acc * xv + mc[i];
            if (s > 32767 || s < -32768) ov = 1'b1;
            if (sat) begin
                acc = (s > 32767) ? 32767 : ((s < -32768) ? -32768 : s);
            end else begin
                wv = s & 64'hFFFF;
                if (wv >= 32768) wv = wv - 65536;
                acc = wv;
            end
        end
        yv = int'(acc);
    endfunction

    task automatic coef_write(input int addr, input int data);
        coef_we    = 1'b1;
        coef_addr  = addr[1:0];
        coef_wdata = data[W-1:0];
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    // Called at a negedge with the engine in IDLE; returns at a negedge back in IDLE.
    task automatic run_txn(input int xv, input int hold);
        exp_t e;
        int lat;
        logic [W-1:0] yh;
        check("idle_state", state_s, 0);
        check("idle_in_ready", in_ready_s, 1);
        model(xv, 1'b1, e.ys, e.os);
        model(xv, 1'b0, e.yw, e.ow);
        x        = xv[W-1:0];
        in_valid = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        coef_we = 1'b0;
        if (!keep_valid) begin
            in_valid = 1'b0;
            x        = W'($urandom);
        end
        lat = 0;
        while (!out_valid_s && lat < 20) begin
            check("busy_state", state_s, (lat == 0) ? 1 : 2);
            check("busy_in_ready", in_ready_s, 0);
            if (busy_wr && lat == 1) begin
                coef_we    = 1'b1;
                coef_addr  = 2'd2;
                coef_wdata = 16'd99;
            end
            @(negedge clk);
            coef_we = 1'b0;
            lat++;
        end
        check("latency", lat, 3);
        check("wrap_out_valid", out_valid_w, 1);
        check("done_state", state_s, 3);
        e = sb.pop_front();
        check("y_sat", $signed(y_s), e.ys);
        check("ovf_sat", ovf_s, e.os);
        check("y_wrap", $signed(y_w), e.yw);
        check("ovf_wrap", ovf_w, e.ow);
        last_ys = int'($signed(y_s));
        last_yw = int'($signed(y_w));
        yh = y_s;
        repeat (hold) begin
            @(negedge clk);
            check("hold_y", y_s, yh);
            check("hold_out_valid", out_valid_s, 1);
            check("hold_in_ready", in_ready_s, 0);
            check("hold_state", state_s, 3);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_state", state_s, 0);
        check("release_out_valid", out_valid_s, 0);
        check("ovf_after_release", ovf_s, e.os);
    endtask

    initial begin
        rst = 1'b1; x = '0; in_valid = 1'b0; out_ready = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        busy_wr = 1'b0; keep_valid = 1'b0;
        mc[0] = 6; mc[1] = 4; mc[2] = 2;
        repeat (2) @(negedge clk);
        check("rst_y", y_s, 0);
        check("rst_out_valid", out_valid_s, 0);
        check("rst_ovf", ovf_s, 0);
        check("rst_in_ready", in_ready_s, 1);
        check("rst_state", state_s, 0);
        rst = 1'b0;
        @(negedge clk);

        run_txn(3, 0);
        check("t1_y36", last_ys, 36);
        run_txn(-5, 0);
        check("t2_neg5", last_ys, 36);
        run_txn(0, 2);
        check("t2_zero", last_ys, 6);

        // in_valid stays high: the second accept must wait for DONE->IDLE
        keep_valid = 1'b1;
        run_txn(7, 3);
        keep_valid = 1'b0;
        run_txn(7, 0);
        check("t2_b2b", last_ys, 132);

        run_txn(200, 0);
        check("t3_sat", last_ys, 32767);
        check("t3_wrap", last_yw, 15270);
        check("t3_ovf", ovf_s, 1);
        run_txn(1, 0);
        check("t3_clean", last_ys, 12);
        check("t3_ovf_clear", ovf_s, 0);

        coef_write(2, 0);
        mc[2] = 0;
        run_txn(3, 0);
        check("t4_wr_idle", last_ys, 18);
        busy_wr = 1'b1;
        run_txn(3, 0);
        busy_wr = 1'b0;
        check("t4_wr_calc", last_ys, 18);
        coef_write(3, 77);
        run_txn(3, 0);
        check("t4_wr_addr3", last_ys, 18);

        coef_we = 1'b1; coef_addr = 2'd2; coef_wdata = 16'd1;
        mc[2] = 1;
        run_txn(3, 0);
        check("t4_wr_same_edge", last_ys, 27);

        run_txn(2, 5);
        check("t5_hold", last_ys, 18);

        x = 16'd200; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("t6_pre_state", state_s, 2);
        #2 rst = 1'b1;
        #1;
        check("t6_state", state_s, 0);
        check("t6_y", y_s, 0);
        check("t6_out_valid", out_valid_s, 0);
        check("t6_ovf", ovf_s, 0);
        check("t6_in_ready", in_ready_s, 1);
        check("t6_wrap_y", y_w, 0);
        @(negedge clk);
        rst = 1'b0;
        mc[0] = 6; mc[1] = 4; mc[2] = 2;
        @(negedge clk);
        check("t6_no_output", out_valid_s, 0);
        run_txn(3, 0);
        check("t6_coef_revert", last_ys, 36);
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
